// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_BR   = 2'b10,
    PC_REG  = 2'b11
  } pc_sel_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Next-PC request/response bundle between the fetch controller and pc_next.
interface instr_fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 64
) ();

  logic [ADDR_W-1:0] pc;
  pc_sel_e           sel;
  logic [25:0]       br_offset;
  logic [ADDR_W-1:0] reg_target;
  logic [ADDR_W-1:0] next_pc;
  logic              misalign;

  modport master (output pc, sel, br_offset, reg_target, input next_pc, misalign);
  modport slave  (input pc, sel, br_offset, reg_target, output next_pc, misalign);

endinterface

// File: rtl/pc_next.sv
// Combinational next-PC selector; a misaligned register target holds the PC and flags it.
module pc_next
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  instr_fetch_if.slave nx
);

  logic [ADDR_W-1:0] w_br_disp;

  // Word offset is sign-extended to the full PC width before scaling to bytes.
  assign w_br_disp = {{(ADDR_W-26){nx.br_offset[25]}}, nx.br_offset} << 2;

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    nx.next_pc  = nx.pc;
    nx.misalign = 1'b0;
    unique case (nx.sel)
      PC_HOLD: ;
      PC_INC:  nx.next_pc = nx.pc + ADDR_W'(4);
      PC_BR:   nx.next_pc = nx.pc + w_br_disp;
      PC_REG: begin
        if (nx.reg_target[1:0] != 2'b00) nx.misalign = 1'b1;
        else                             nx.next_pc  = nx.reg_target;
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, two-state fetch FSM with ready timeout, instruction latch.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               IL,
  input  logic               PC_EN,
  input  logic [1:0]         PC_SEL,
  input  logic [25:0]        BR_OFFSET,
  input  logic [ADDR_W-1:0]  REG_TARGET,
  input  logic [INSTR_W-1:0] MEM_RDATA,
  input  logic               MEM_READY,
  output logic [ADDR_W-1:0]  ADDR,
  output logic               RCS,
  output logic               RR,
  output logic               EN_ADDR_PC,
  output logic [INSTR_W-1:0] Inst,
  output logic [ADDR_W-1:0]  PC,
  output logic               INST_VALID,
  output logic               BUSY,
  output logic               FAULT
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_e       r_state, w_state_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_inst;
  logic               r_inst_valid;
  logic               r_fault;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_done, w_timeout, w_busy, w_pc_update;

  instr_fetch_if #(.ADDR_W(ADDR_W)) w_nx ();

  assign w_nx.pc         = r_pc;
  assign w_nx.sel        = pc_sel_e'(PC_SEL);
  assign w_nx.br_offset  = BR_OFFSET;
  assign w_nx.reg_target = REG_TARGET;

  pc_next #(.ADDR_W(ADDR_W)) u_pc_next (.nx(w_nx.slave));

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    w_busy       = 1'b0;
    ADDR         = '0;
    unique case (r_state)
      S_IDLE: begin
        if (IL) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        w_busy = 1'b1;
        ADDR   = r_pc;
        if (MEM_READY) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
    endcase
  end

  // PC_EN only takes effect in IDLE; with IL in the same cycle the fetch sees the new PC.
  assign w_pc_update = (r_state == S_IDLE) && PC_EN;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc         <= '0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_inst_valid <= w_done;
      if (w_done) r_inst <= MEM_RDATA;

      if (r_state == S_FETCH && !w_done && !w_timeout) r_cnt <= r_cnt + CNT_W'(1);
      else                                             r_cnt <= '0;

      if (w_pc_update) r_pc <= w_nx.next_pc;

      // A misaligned target in the accepting cycle wins over the clear from IL.
      if ((w_pc_update && w_nx.misalign) || w_timeout) r_fault <= 1'b1;
      else if (r_state == S_IDLE && IL)                r_fault <= 1'b0;
    end
  end

  assign RCS        = w_busy;
  assign RR         = w_busy;
  assign EN_ADDR_PC = w_busy;
  assign BUSY       = w_busy;
  assign Inst       = r_inst;
  assign PC         = r_pc;
  assign INST_VALID = r_inst_valid;
  assign FAULT      = r_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: PC-update vector table plus fetch, timeout and reset sequences.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        IL, PC_EN, MEM_READY;
  logic [1:0]  PC_SEL;
  logic [25:0] BR_OFFSET;
  logic [63:0] REG_TARGET, ADDR, PC;
  logic [31:0] MEM_RDATA, Inst;
  logic        RCS, RR, EN_ADDR_PC, INST_VALID, BUSY, FAULT;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  instr_fetch #(.ADDR_W(64), .TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n), .IL(IL), .PC_EN(PC_EN), .PC_SEL(PC_SEL),
    .BR_OFFSET(BR_OFFSET), .REG_TARGET(REG_TARGET), .MEM_RDATA(MEM_RDATA),
    .MEM_READY(MEM_READY), .ADDR(ADDR), .RCS(RCS), .RR(RR), .EN_ADDR_PC(EN_ADDR_PC),
    .Inst(Inst), .PC(PC), .INST_VALID(INST_VALID), .BUSY(BUSY), .FAULT(FAULT)
  );

  // Standalone selector for direct misalign-flag checks.
  instr_fetch_if #(.ADDR_W(64)) u_nx_if ();
  pc_next #(.ADDR_W(64)) u_pc_next (.nx(u_nx_if.slave));

  typedef struct {
    logic        pc_en;
    logic [1:0]  sel;
    logic [25:0] off;
    logic [63:0] tgt;
    logic [63:0] exp_pc;
    logic        exp_fault;
  } pc_vec_t;

  pc_vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic valid_seen;

    vecs[0]  = '{1'b1, 2'b11, 26'd0,         64'h100,                 64'h100,                 1'b0};
    vecs[1]  = '{1'b1, 2'b10, 26'h3FF_FFFC,  64'h0,                   64'hF0,                  1'b0};
    vecs[2]  = '{1'b1, 2'b01, 26'd0,         64'h0,                   64'hF4,                  1'b0};
    vecs[3]  = '{1'b1, 2'b00, 26'd0,         64'h0,                   64'hF4,                  1'b0};
    vecs[4]  = '{1'b0, 2'b01, 26'd0,         64'h0,                   64'hF4,                  1'b0};
    vecs[5]  = '{1'b1, 2'b11, 26'd0,         64'h203,                 64'hF4,                  1'b1};
    vecs[6]  = '{1'b1, 2'b10, 26'h10,        64'h0,                   64'h134,                 1'b1};
    vecs[7]  = '{1'b1, 2'b11, 26'd0,         64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1};
    vecs[8]  = '{1'b1, 2'b01, 26'd0,         64'h0,                   64'h0,                   1'b1};
    vecs[9]  = '{1'b1, 2'b10, 26'h3FF_FFFF,  64'h0,                   64'hFFFF_FFFF_FFFF_FFFC, 1'b1};
    vecs[10] = '{1'b1, 2'b10, 26'h1,         64'h0,                   64'h0,                   1'b1};
    vecs[11] = '{1'b1, 2'b10, 26'h1FF_FFFF,  64'h0,                   64'h7FF_FFFC,            1'b1};
    vecs[12] = '{1'b1, 2'b10, 26'h200_0000,  64'h0,                   64'hFFFF_FFFF_FFFF_FFFC, 1'b1};
    vecs[13] = '{1'b1, 2'b11, 26'd0,         64'h10,                  64'h10,                  1'b1};

    reset_n = 1'b0; IL = 1'b0; PC_EN = 1'b0; PC_SEL = 2'b00; BR_OFFSET = '0;
    REG_TARGET = '0; MEM_RDATA = '0; MEM_READY = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_pc", PC, 64'h0);
    check("rst_inst", {32'h0, Inst}, 64'h0);
    check("rst_strobes", {58'h0, INST_VALID, BUSY, FAULT, RCS, RR, EN_ADDR_PC}, 64'h0);
    check("rst_addr", ADDR, 64'h0);
    reset_n = 1'b1;

    // Minimum-latency fetch
    @(negedge clock);
    IL = 1'b1; MEM_READY = 1'b1; MEM_RDATA = 32'h8B02_0020;
    tick();
    check("f1_busy", {61'h0, BUSY, RCS, RR}, 64'h7);
    check("f1_en_addr", {63'h0, EN_ADDR_PC}, 64'h1);
    check("f1_addr", ADDR, 64'h0);
    check("f1_valid_early", {63'h0, INST_VALID}, 64'h0);
    @(negedge clock);
    IL = 1'b0;
    tick();
    check("f1_valid", {63'h0, INST_VALID}, 64'h1);
    check("f1_inst", {32'h0, Inst}, 64'h8B02_0020);
    check("f1_idle", {63'h0, BUSY}, 64'h0);
    check("f1_pc", PC, 64'h0);
    tick();
    check("f1_valid_pulse", {63'h0, INST_VALID}, 64'h0);
    check("f1_inst_hold", {32'h0, Inst}, 64'h8B02_0020);

    // PC update table (all in IDLE)
    @(negedge clock);
    MEM_READY = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      PC_EN = vecs[i].pc_en; PC_SEL = vecs[i].sel;
      BR_OFFSET = vecs[i].off; REG_TARGET = vecs[i].tgt;
      tick();
      check($sformatf("vec%0d_pc", i), PC, vecs[i].exp_pc);
      check($sformatf("vec%0d_fault", i), {63'h0, FAULT}, {63'h0, vecs[i].exp_fault});
      @(negedge clock);
      PC_EN = 1'b0;
    end

    // IL+PC_EN together: fetch uses the updated PC; FETCH ignores PC_EN and IL
    @(negedge clock);
    IL = 1'b1; PC_EN = 1'b1; PC_SEL = 2'b01;
    tick();
    check("ilpc_pc", PC, 64'h14);
    check("ilpc_addr", ADDR, 64'h14);
    check("ilpc_busy", {63'h0, BUSY}, 64'h1);
    check("ilpc_fault_clr", {63'h0, FAULT}, 64'h0);
    tick();
    check("fetch_pcen_ignored", PC, 64'h14);
    check("fetch_il_busy", {63'h0, BUSY}, 64'h1);
    @(negedge clock);
    IL = 1'b0; PC_EN = 1'b0; MEM_READY = 1'b1; MEM_RDATA = 32'h1234_5678;
    tick();
    check("late_ready_valid", {63'h0, INST_VALID}, 64'h1);
    check("late_ready_inst", {32'h0, Inst}, 64'h1234_5678);
    check("late_ready_idle", {63'h0, BUSY}, 64'h0);
    @(negedge clock);
    MEM_READY = 1'b0; MEM_RDATA = 32'hCAFE_F00D;

    // Timeout after 15 FETCH cycles without MEM_READY
    @(negedge clock);
    IL = 1'b1;
    tick();
    @(negedge clock);
    IL = 1'b0;
    valid_seen = 1'b0;
    for (int i = 1; i < 15; i++) begin
      tick();
      valid_seen = valid_seen | INST_VALID;
    end
    check("to_busy_14", {63'h0, BUSY}, 64'h1);
    check("to_nofault_14", {63'h0, FAULT}, 64'h0);
    tick();
    valid_seen = valid_seen | INST_VALID;
    check("to_idle_15", {63'h0, BUSY}, 64'h0);
    check("to_fault_15", {63'h0, FAULT}, 64'h1);
    check("to_no_valid", {63'h0, valid_seen}, 64'h0);
    check("to_inst_hold", {32'h0, Inst}, 64'h1234_5678);
    tick();
    check("to_stay_idle", {62'h0, BUSY, FAULT}, 64'h1);

    // Reset during FETCH
    @(negedge clock);
    IL = 1'b1;
    tick();
    @(negedge clock);
    IL = 1'b0;
    check("rf_busy", {63'h0, BUSY}, 64'h1);
    check("rf_fault_clr", {63'h0, FAULT}, 64'h0);
    #2 reset_n = 1'b0;
    #1;
    check("rf_strobes", {61'h0, RCS, RR, BUSY}, 64'h0);
    check("rf_pc", PC, 64'h0);
    check("rf_addr", ADDR, 64'h0);
    MEM_READY = 1'b1; MEM_RDATA = 32'hDEAD_BEEF;
    tick();
    check("rf_no_valid", {63'h0, INST_VALID}, 64'h0);
    check("rf_inst", {32'h0, Inst}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("rf_need_il", {62'h0, BUSY, INST_VALID}, 64'h0);
    @(negedge clock);
    IL = 1'b1;
    tick();
    @(negedge clock);
    IL = 1'b0;
    tick();
    check("rf_fresh_valid", {63'h0, INST_VALID}, 64'h1);
    check("rf_fresh_inst", {32'h0, Inst}, 64'hDEAD_BEEF);

    // Direct selector checks
    u_nx_if.pc = 64'h1000; u_nx_if.sel = PC_REG; u_nx_if.br_offset = '0;
    u_nx_if.reg_target = 64'h202;
    #1;
    check("nx_mis2_flag", {63'h0, u_nx_if.misalign}, 64'h1);
    check("nx_mis2_pc", u_nx_if.next_pc, 64'h1000);
    u_nx_if.reg_target = 64'h201;
    #1;
    check("nx_mis1_flag", {63'h0, u_nx_if.misalign}, 64'h1);
    u_nx_if.reg_target = 64'h2000;
    #1;
    check("nx_align_flag", {63'h0, u_nx_if.misalign}, 64'h0);
    check("nx_align_pc", u_nx_if.next_pc, 64'h2000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, PC and memory address width.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum wait cycles for mem_ready before fault.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IL  input  1  instruction-load strobe; starts a fetch at current PC.
REQ-006 SHALL have port PC_EN  input  1  one-cycle strobe; applies PC_SEL to PC.
REQ-007 SHALL have port PC_SEL  input  2  next-PC select; 00 hold, 01 PC+4, 10 PC+(BR_OFFSET<<2), 11 REG_TARGET.
REQ-008 SHALL have port BR_OFFSET  input  26  signed word offset for branches.
REQ-009 SHALL have port REG_TARGET  input  ADDR_W  absolute target for register branch.
REQ-010 SHALL have port MEM_RDATA  input  32  instruction word from RAM.
REQ-011 SHALL have port MEM_READY  input  1  RAM read data valid.
REQ-012 SHALL have port ADDR  output  ADDR_W  RAM address bus drive.
REQ-013 SHALL have ports RCS, RR, EN_ADDR_PC  output  1 each  chip select, read strobe, PC-to-address-bus enable.
REQ-014 SHALL have port Inst  output  32  registered instruction word to control unit.
REQ-015 SHALL have port PC  output  ADDR_W  current program counter.
REQ-016 SHALL have ports INST_VALID, BUSY, FAULT  output  1 each  new-instruction pulse, fetch in progress, sticky error.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH; BUSY=1 exactly in FETCH.
REQ-018 In IDLE, IL=1 SHALL move to FETCH next cycle and clear FAULT.
REQ-019 In FETCH, SHALL drive ADDR=PC, RCS=RR=EN_ADDR_PC=1; in IDLE these SHALL be 0 and ADDR=0.
REQ-020 In FETCH with MEM_READY=1, SHALL register MEM_RDATA into Inst, pulse INST_VALID for one cycle next edge, return to IDLE.
REQ-021 Minimum latency SHALL be 2 cycles from IL edge to INST_VALID when MEM_READY is high on first FETCH cycle.
REQ-022 Inst SHALL hold its value until the next successful fetch.
REQ-023 SHALL count FETCH cycles; after TIMEOUT cycles without MEM_READY SHALL set FAULT, leave Inst unchanged, return to IDLE without INST_VALID.
REQ-024 PC_EN in IDLE SHALL update PC per PC_SEL at next edge; PC_EN in FETCH SHALL be ignored.
REQ-025 IL and PC_EN together in IDLE SHALL update PC and start FETCH, which uses the updated PC.
REQ-026 IL during FETCH SHALL be ignored.
REQ-027 PC arithmetic SHALL be modulo 2^ADDR_W; BR_OFFSET sign-extended before shift; 0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
REQ-028 PC_SEL=11 with REG_TARGET[1:0]!=0 SHALL leave PC unchanged and set FAULT.
REQ-029 FAULT SHALL remain set until next accepted IL or reset.

Reset
REQ-030 reset_n low SHALL asynchronously force state IDLE, PC=0, Inst=0, INST_VALID=0, FAULT=0, timeout count=0, all strobes 0.
REQ-031 Reset mid-FETCH SHALL abort the fetch with no INST_VALID; MEM_RDATA SHALL be discarded.
REQ-032 After reset release, first action SHALL require a fresh IL.

Structure
REQ-033 Shared package fetch_pkg SHALL hold PC_SEL encodings, FSM state type, instruction width 32.
REQ-034 Next-PC computation SHALL be a combinational sub-module pc_next (PC, PC_SEL, BR_OFFSET, REG_TARGET -> next PC, misalign flag).

Verification
REQ-035 Reset, IL with MEM_READY=1, MEM_RDATA=0x8B020020 -> INST_VALID two cycles after IL, Inst=0x8B020020, PC=0.
REQ-036 PC=0x100, PC_EN, PC_SEL=10, BR_OFFSET=-4 -> PC=0xF0; PC_SEL=01 -> PC=0xF4.
REQ-037 PC_SEL=11, REG_TARGET=0x203 -> PC unchanged, FAULT=1; next IL -> FAULT=0.
REQ-038 IL, MEM_READY held low 15 cycles -> FAULT=1, no INST_VALID, state IDLE, Inst unchanged.
REQ-039 IL+PC_EN(PC_SEL=01) same cycle from PC=0x10 -> ADDR=0x14 during FETCH.
REQ-040 reset_n low during FETCH then MEM_READY -> no INST_VALID, PC=0, RCS=RR=0 immediately.
